// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: funct3 encodings, FSM states, access sizes, bus bundle.
// No logic, no latency.
// No flow control.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_bus_t;

    // funct3 encoding 11 has no distinct size; it behaves as a word.
    function automatic access_size_t size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering for loads and stores: byte enables, store replication, misalign, load extension.
// Purely combinational, zero latency.
// No flow control.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    access_size_t size;
    logic [31:0]  lane;

    always_comb begin
        size       = size_of(funct3[1:0]);
        lane       = rdata >> {addr_lo, 3'b000};
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        load_data  = rdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
                load_data  = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX/MEM loads/stores into a ready/valid data-bus transaction and feeds MEM/WB.
// Latency: store >=1 stall cycle, load >=2 stall cycles, then one DONE cycle; bounded by TIMEOUT_CYCLES.
// Backpressure: stall_out holds IF..EX/MEM while a request waits for dmem_ready or data waits for dmem_rvalid.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  read_rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [31:0] data_address_out,
    output logic [4:0]  read_rd_out,
    output logic [31:0] data_mem_out,
    output logic        stall_out,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        squash_q, squash_d;
    logic        bus_err_q, bus_err_d;
    dmem_bus_t   req_q, req_d;

    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misalign_c;
    logic [31:0] load_data_c;
    logic        mem_access, mem_op, is_load, timeout;
    dmem_bus_t   bus_c, bus_out;

    load_store_align u_align (
        .addr_lo    (alu_result_in[1:0]),
        .funct3     (funct3_in),
        .store_data (store_data_in),
        .rdata      (rdata_q),
        .be         (be_c),
        .wdata      (wdata_c),
        .misaligned (misalign_c),
        .load_data  (load_data_c)
    );

    assign mem_access = valid_in & (mem_read_in | mem_write_in);
    assign mem_op     = mem_access & ~misalign_c;
    assign is_load    = mem_op & ~mem_write_in;
    assign timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        bus_c.we    = mem_write_in;
        bus_c.be    = be_c;
        bus_c.addr  = {alu_result_in[31:2], 2'b00};
        bus_c.wdata = wdata_c;
    end

    // A bus completion on the final allowed cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        rdata_d   = rdata_q;
        squash_d  = squash_q;
        bus_err_d = 1'b0;
        req_d     = req_q;
        case (state_q)
            IDLE: begin
                squash_d = mem_op & flush;
                if (mem_op) begin
                    req_d = bus_c;
                    if (dmem_ready) state_d = mem_write_in ? DONE : RESP;
                    else            state_d = REQ;
                end
            end
            REQ: begin
                cnt_d    = cnt_q + 1'b1;
                squash_d = squash_q | flush;
                if (dmem_ready) begin
                    state_d = req_q.we ? DONE : RESP;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d    = cnt_q + 1'b1;
                squash_d = squash_q | flush;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                squash_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            squash_q  <= 1'b0;
            bus_err_q <= 1'b0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            squash_q  <= squash_d;
            bus_err_q <= bus_err_d;
            req_q     <= req_d;
        end
    end

    // While waiting the bus sees the latched request, so it stays stable whatever EX/MEM does.
    assign bus_out    = (state_q == IDLE) ? bus_c : req_q;
    assign dmem_we    = bus_out.we;
    assign dmem_be    = bus_out.be;
    assign dmem_addr  = bus_out.addr;
    assign dmem_wdata = bus_out.wdata;

    assign dmem_req   = ~reset & (((state_q == IDLE) & mem_op) | (state_q == REQ));
    assign stall_out  = ~reset & (((state_q == IDLE) & mem_op) | (state_q == REQ) | (state_q == RESP));
    assign misaligned = ~reset & (state_q == IDLE) & mem_access & misalign_c;
    assign bus_error  = bus_err_q;

    assign mem_to_reg_out   = mem_to_reg_in;
    assign data_address_out = alu_result_in;
    assign read_rd_out      = read_rd_in;
    assign data_mem_out     = is_load ? load_data_c : 32'b0;
    assign reg_write_out    = reg_write_in & valid_in & ~flush & ~squash_q & ~bus_err_q
                              & ~(mem_access & misalign_c);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected op results.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset, valid_in, flush, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic        mem_to_reg_in, reg_write_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  read_rd_in;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_to_reg_out, reg_write_out;
    logic [31:0] data_address_out;
    logic [4:0]  read_rd_out;
    logic [31:0] data_mem_out;
    logic        stall_out, misaligned, bus_error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        rw;
        logic        berr;
        logic        mis;
        int          stalls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .flush(flush),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .read_rd_in(read_rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .data_address_out(data_address_out), .read_rd_out(read_rd_out),
        .data_mem_out(data_mem_out), .stall_out(stall_out), .misaligned(misaligned),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] data, input logic chk_data, input logic rw,
                                input logic berr, input logic mis, input int stalls,
                                input logic we, input logic [3:0] be, input logic [31:0] baddr,
                                input logic [31:0] wdata);
        exp_t e;
        e.data = data; e.chk_data = chk_data; e.rw = rw; e.berr = berr; e.mis = mis;
        e.stalls = stalls; e.we = we; e.be = be; e.baddr = baddr; e.wdata = wdata;
        return e;
    endfunction

    task automatic cycle;
        @(posedge clock);
        #1;
    endtask

    // Entered 1ns after a posedge; returns 1ns after the posedge following the op's final cycle.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic rwin,
                          input int rdy_d, input int rv_d, input int fl_c,
                          input logic [31:0] rdata, input exp_t e);
        exp_t x;
        int   stalls = 0;
        bit   done = 0;
        sb.push_back(e);
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        alu_result_in = addr; store_data_in = sd; reg_write_in = rwin;
        mem_to_reg_in = rd; read_rd_in = 5'd7;
        for (int k = 0; k < 20 && !done; k++) begin
            dmem_ready  = (k == rdy_d);
            dmem_rvalid = (rv_d >= 0) && (k == rdy_d + rv_d);
            dmem_rdata  = dmem_rvalid ? rdata : 32'h0BAD0BAD;
            flush       = (k == fl_c);
            #4;
            if (stall_out) begin
                stalls++;
                if (dmem_req) begin
                    check({tag, "_we"}, 32'(dmem_we), 32'(sb[0].we));
                    check({tag, "_be"}, 32'(dmem_be), 32'(sb[0].be));
                    check({tag, "_addr"}, dmem_addr, sb[0].baddr);
                    check({tag, "_wdata"}, dmem_wdata, sb[0].wdata);
                end
            end else begin
                x = sb.pop_front();
                done = 1;
                check({tag, "_stalls"}, 32'(stalls), 32'(x.stalls));
                if (x.chk_data) check({tag, "_data"}, data_mem_out, x.data);
                check({tag, "_regwr"}, 32'(reg_write_out), 32'(x.rw));
                check({tag, "_buserr"}, 32'(bus_error), 32'(x.berr));
                check({tag, "_misal"}, 32'(misaligned), 32'(x.mis));
                check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
                check({tag, "_daddr"}, data_address_out, addr);
                check({tag, "_rd"}, 32'(read_rd_out), 32'd7);
                check({tag, "_m2r"}, 32'(mem_to_reg_out), 32'(rd));
            end
            cycle();
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        if (!done && sb.size() > 0) void'(sb.pop_front());
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; flush = 1'b0;
        reg_write_in = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = 3'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0; alu_result_in = 32'h0;
        store_data_in = 32'h0; read_rd_in = 5'd0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) cycle();
        #4;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_berr", 32'(bus_error), 32'd0);
        check("rst_misal", 32'(misaligned), 32'd0);
        check("rst_regwr", 32'(reg_write_out), 32'd0);
        check("rst_data", data_mem_out, 32'd0);
        cycle();
        reset = 1'b0;
        cycle();

        run_op("sw", 1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 1'b0, 0, -1, -1, 32'h0,
               mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF));
        run_op("lb", 1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 1'b1, 0, 1, -1, 32'h80AABBCC,
               mk(32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'b1000, 32'h100, 32'h0));
        run_op("lbu", 1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 1'b1, 0, 1, -1, 32'h80AABBCC,
               mk(32'h00000080, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'b1000, 32'h100, 32'h0));
        run_op("lb1", 1'b1, 1'b0, F3_LB, 32'h101, 32'h0, 1'b1, 0, 1, -1, 32'h80AABBCC,
               mk(32'hFFFFFFBB, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'b0010, 32'h100, 32'h0));
        run_op("lhu", 1'b1, 1'b0, F3_LHU, 32'h100, 32'h0, 1'b1, 0, 1, -1, 32'h80AABBCC,
               mk(32'h0000BBCC, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'b0011, 32'h100, 32'h0));
        run_op("sh", 1'b0, 1'b1, F3_SH, 32'h202, 32'h00001234, 1'b0, 3, -1, -1, 32'h0,
               mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 4'b1100, 32'h200, 32'h12341234));
        run_op("lw_wait", 1'b1, 1'b0, F3_LW, 32'h104, 32'h0, 1'b1, 1, 1, -1, 32'hCAFEF00D,
               mk(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 4'b1111, 32'h104, 32'h0));

        run_op("lw_mis", 1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 1'b1, 0, 1, -1, 32'h0,
               mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'b1111, 32'h100, 32'h0));
        #4;
        check("mis_pulse_end", 32'(misaligned), 32'd0);
        cycle();

        run_op("lw_tmo", 1'b1, 1'b0, F3_LW, 32'h108, 32'h0, 1'b1, 0, -1, -1, 32'h0,
               mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 4'b1111, 32'h108, 32'h0));
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD0BAD;
        #4;
        check("berr_pulse_end", 32'(bus_error), 32'd0);
        check("late_rvalid_stall", 32'(stall_out), 32'd0);
        cycle();
        dmem_rvalid = 1'b0;

        run_op("lh_flush", 1'b1, 1'b0, F3_LH, 32'h102, 32'h0, 1'b1, 0, 2, 1, 32'h80012345,
               mk(32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 4'b1100, 32'h100, 32'h0));
        run_op("alu_op", 1'b0, 1'b0, 3'b000, 32'h55AA, 32'h0, 1'b1, -1, -1, -1, 32'h0,
               mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0, 32'h0));
        run_op("alu_flush", 1'b0, 1'b0, 3'b000, 32'h55AC, 32'h0, 1'b1, -1, -1, 0, 32'h0,
               mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0, 32'h0));

        // Reset while a load waits in REQ.
        valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = F3_LW; alu_result_in = 32'h10C;
        reg_write_in = 1'b1; dmem_ready = 1'b0;
        #4;
        check("rreq_idle_req", 32'(dmem_req), 32'd1);
        cycle();
        #4;
        check("rreq_req_held", 32'(dmem_req), 32'd1);
        check("rreq_addr", dmem_addr, 32'h10C);
        cycle();
        reset = 1'b1;
        #4;
        check("rreq_req_drop", 32'(dmem_req), 32'd0);
        check("rreq_stall_drop", 32'(stall_out), 32'd0);
        cycle();
        reset = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; reg_write_in = 1'b0;
        #4;
        check("rreq_after_req", 32'(dmem_req), 32'd0);
        check("rreq_after_stall", 32'(stall_out), 32'd0);
        cycle();
        run_op("sw_after_rst", 1'b0, 1'b1, F3_SB, 32'h301, 32'h000000A5, 1'b0, 0, -1, -1, 32'h0,
               mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 4'b0010, 32'h300, 32'hA5A5A5A5));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM pipeline stage that sits between the EX/MEM register and the MEM/WB register.
- Turns a load or store from EX/MEM into a data-memory bus transaction with a ready/valid handshake and wait-state support.
- Aligns and sign/zero-extends load data, and holds the pipeline with `stall_out` while a transaction is outstanding.
- Flags misaligned accesses and bus timeouts, and suppresses register write-back for those operations.

Parameters:
- TIMEOUT_CYCLES, 64: cycles spent in REQ+RESP before `bus_error` is raised; must be ≥2.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  EX/MEM holds a live instruction.
- flush  in  1  squash write-back of the current op.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- funct3_in  in  3  access size/sign.
- mem_to_reg_in  in  1  WB control, passed through.
- reg_write_in  in  1  WB control.
- alu_result_in  in  32  effective address / ALU result.
- store_data_in  in  32  rs2 value.
- read_rd_in  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word-aligned address, {alu_result_in[31:2],2'b00}.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- mem_to_reg_out  out  1  to MEM/WB.
- reg_write_out  out  1  to MEM/WB.
- data_address_out  out  32  to MEM/WB.
- read_rd_out  out  5  to MEM/WB.
- data_mem_out  out  32  to MEM/WB, extended load data.
- stall_out  out  1  hazard unit holds IF..EX/MEM.
- misaligned  out  1  one-cycle pulse.
- bus_error  out  1  one-cycle pulse.

Behaviour:
- Reset (sync, high): state=IDLE, counter=0, rdata_q=0, squash_q=0. All registered outputs are 0, and `dmem_req`=0 and `stall_out`=0 are forced.
- Access sizes by funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = word. funct3[2]=1 selects zero-extension on loads and is ignored for stores.
- Byte enables:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - Half: be = 0011 << addr[1:0]; wdata = {2{sd[15:0]}}.
  - Word: be = 1111; wdata = sd.
  - Reads drive the same be.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. No bus request is issued; `misaligned` pulses for 1 cycle; `reg_write_out`=0; `stall_out`=0.
- Memory op: valid_in & (mem_read_in | mem_write_in) & aligned. If both read and write are set, the op is a store.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE + memory op: `dmem_req`=1 combinationally and `stall_out`=1. If `dmem_ready` is high, go to RESP for a load or DONE for a store. Otherwise go to REQ.
  - REQ: hold `dmem_req` and all bus fields stable until `dmem_ready`. The request is never withdrawn, even on flush. On ready, go to RESP (load) or DONE (store).
  - RESP: wait for `dmem_rvalid`; latch `rdata_q` <= dmem_rdata; go to DONE. `dmem_rvalid` is only honoured in RESP and is ignored elsewhere.
  - DONE: `stall_out`=0. Outputs present the completed op. Next state is IDLE. The pipeline advances this cycle, so the same op is never re-issued.
  - `stall_out`=1 in IDLE(with a memory op), REQ and RESP; 0 otherwise.
- Minimum latency:
  - Load: 2 stall cycles (IDLE-with-ready, then RESP with rvalid on the next cycle), then DONE.
  - Store: 1 stall cycle, then DONE.
- Load extension: select the lane by addr[1:0] from `rdata_q`, then sign-extend (funct3[2]=0) or zero-extend. Examples: LB of 0x80 gives 0xFFFFFF80; LBU gives 0x00000080.
- Outputs for non-memory ops and stores are combinational pass-through:
  - `data_address_out` = alu_result_in.
  - `read_rd_out` = read_rd_in.
  - `mem_to_reg_out` = mem_to_reg_in.
  - `reg_write_out` = reg_write_in & valid_in & ~flush & ~squash_q.
  - `data_mem_out` = 0 for non-loads.
- Timeout:
  - The counter increments each cycle in REQ or RESP and clears in IDLE/DONE.
  - At TIMEOUT_CYCLES: `bus_error` pulses, go to DONE, and `reg_write_out`=0 for that op.
  - A late rvalid or ready arriving after the timeout is ignored.
- Flush during REQ or RESP: the transaction completes on the bus, and squash_q=1 forces `reg_write_out`=0 in DONE. squash_q clears in IDLE.
- Reset mid-transaction: return to IDLE immediately and drop `dmem_req`. The bus slave is reset by the same signal.

Decomposition:
- Package `mem_pkg`: funct3 size/sign constants (LB/LH/LW/LBU/LHU/SB/SH/SW), the `mem_state_t` enum {IDLE, REQ, RESP, DONE}, and the access-size enum.
- One combinational sub-module `load_store_align`: computes be, wdata lane replication, misalign detection, and load extraction/extension.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready in the same cycle → be=1111, wdata=0xDEADBEEF, stall for 1 cycle, DONE, reg_write_out=0.
- LB addr 0x103, rdata 0x80AABBCC, ready then rvalid on the next cycle → stall for 2 cycles, data_mem_out=0xFFFFFF80; repeat as LBU → 0x00000080.
- SH addr 0x202, data 0x1234, ready delayed 3 cycles → dmem_req held with stable be=1100 and wdata=0x12341234; stall for 4 cycles.
- LW addr 0x101 → no dmem_req, misaligned pulses once, reg_write_out=0, stall_out=0.
- LW with TIMEOUT_CYCLES=4 and rvalid never asserted → bus_error pulses after 4 cycles in REQ/RESP, stall releases, reg_write_out=0.
- LH in RESP with flush pulsed, then rvalid → transaction completes, reg_write_out=0 in DONE; reset asserted in REQ → dmem_req=0 on the next cycle, state IDLE.
